// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter:
//                ownership state encoding, port identifiers and default sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Ownership state: nobody, port 0 or port 1 held the last grant.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Port identifiers as carried on the winner / last_port signals.
    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

    // Default geometry.
    localparam int c_DEFAULT_AW        = 32;
    localparam int c_DEFAULT_DW        = 32;
    localparam int c_DEFAULT_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Purely combinational winner selection. A lone requester
//                always wins; on a tie the current owner keeps the grant
//                until its burst budget is spent, and from IDLE the port
//                that did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = c_DEFAULT_MAX_BURST,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          req0,
    input  logic          req1,
    input  arb_state_t    state,
    input  logic [CW-1:0] count,
    input  logic          last_port,
    output logic          winner,
    output logic          valid
);

    logic w_at_limit;

    // Owner has used up its consecutive-grant budget.
    assign w_at_limit = (count >= CW'(MAX_BURST));

    // Winner choice; the burst budget only matters when both ports compete.
    always_comb begin
        valid  = req0 | req1;
        winner = c_PORT0;
        if (req0 && req1) begin
            case (state)
                OWN0:    winner = w_at_limit ? c_PORT1 : c_PORT0;
                OWN1:    winner = w_at_limit ? c_PORT0 : c_PORT1;
                default: winner = ~last_port;
            endcase
        end else if (req1) begin
            winner = c_PORT1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port, one-beat-per-cycle memory arbiter with
//                zero-latency grant, bounded bursts under contention and
//                one-cycle read return.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = c_DEFAULT_MAX_BURST,
    parameter int AW        = c_DEFAULT_AW,
    parameter int DW        = c_DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_out,
    output logic          mem_we,
    input  logic [DW-1:0] mem_data_in
);

    localparam int c_CW = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    logic [c_CW-1:0]  r_count;
    logic             r_last_port;
    logic [AW-1:0]    r_addr_hold;
    logic [DW-1:0]    r_wdata_hold;
    logic             r_rvalid0;
    logic             r_rvalid1;

    logic             w_winner;
    logic             w_valid;
    logic             w_grant;
    logic             w_sel_we;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;
    arb_state_t       w_own;

    mem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CW        (c_CW)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .state     (r_state),
        .count     (r_count),
        .last_port (r_last_port),
        .winner    (w_winner),
        .valid     (w_valid)
    );

    // Reset masks the grant combinationally so nothing is accepted while it is high.
    assign w_grant     = w_valid & ~reset;
    assign w_sel_we    = w_winner ? we1    : we0;
    assign w_sel_addr  = w_winner ? addr1  : addr0;
    assign w_sel_wdata = w_winner ? wdata1 : wdata0;
    assign w_own       = w_winner ? OWN1   : OWN0;

    assign gnt0         = w_grant & (w_winner == c_PORT0);
    assign gnt1         = w_grant & (w_winner == c_PORT1);
    assign mem_we       = w_grant & w_sel_we;
    assign mem_address  = w_grant ? w_sel_addr  : r_addr_hold;
    assign mem_data_out = w_grant ? w_sel_wdata : r_wdata_hold;

    // Memory read data is only forwarded when a read return is due.
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = (r_rvalid0 | r_rvalid1) ? mem_data_in : '0;

    // Ownership FSM, burst counter, round-robin pointer, bus hold and read-return flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_last_port  <= c_PORT1;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_grant & ~w_sel_we & (w_winner == c_PORT0);
            r_rvalid1 <= w_grant & ~w_sel_we & (w_winner == c_PORT1);
            if (w_grant) begin
                r_addr_hold  <= w_sel_addr;
                r_wdata_hold <= w_sel_wdata;
                r_last_port  <= w_winner;
                if (r_state == w_own) begin
                    if (r_count != c_CW'(MAX_BURST)) begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    r_state <= w_own;
                    r_count <= c_CW'(1);
                end
            end else begin
                r_state <= IDLE;
                r_count <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios
//                followed by random two-port traffic, compared against a
//                behavioural model of grants, bus contents and read returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MAX_BURST = 4;
    localparam int AW        = 32;
    localparam int DW        = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata, mem_data_out;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MAX_BURST (MAX_BURST),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we),
        .mem_data_in  (mem_data_in)
    );

    // Contents of a never-written word, distinct per address.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory attached to the DUT: one-cycle read latency, write on mem_we.
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    always @(posedge clk) begin
        mem_data_in <= env_mem.exists(mem_address) ? env_mem[mem_address] : init_word(mem_address);
        if (mem_we) env_mem[mem_address] = mem_data_out;
    end

    // Reference model state: who got the previous beat, how many in a row,
    // who won last, what the bus last carried, and any read due this cycle.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            m_own, m_streak, m_last, m_pend;
    logic [AW-1:0] m_hold_addr;
    logic [DW-1:0] m_hold_wdata;
    logic [DW-1:0] m_pend_data;

    logic          last_g0, last_g1, last_rv0, last_rv1, last_we;
    logic [DW-1:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own        = -1;
        m_streak     = 0;
        m_last       = 1;
        m_pend       = -1;
        m_hold_addr  = '0;
        m_hold_wdata = '0;
        m_pend_data  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},    gnt0,         0);
        chk({tag, "_gnt1"},    gnt1,         0);
        chk({tag, "_rvalid0"}, rvalid0,      0);
        chk({tag, "_rvalid1"}, rvalid1,      0);
        chk({tag, "_mem_we"},  mem_we,       0);
        chk({tag, "_addr"},    mem_address,  0);
        chk({tag, "_wdata"},   mem_data_out, 0);
        chk({tag, "_rdata"},   rdata,        0);
    endtask

    // One bus cycle: drive both ports, compare every output with the model, advance the model.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int            win;
        logic          s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wd;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        if (!r0 && !r1)      win = -1;
        else if (r0 && !r1)  win = 0;
        else if (r1 && !r0)  win = 1;
        else if (m_own >= 0) win = (m_streak < MAX_BURST) ? m_own : 1 - m_own;
        else                 win = 1 - m_last;
        s_we   = (win == 1) ? w1 : w0;
        s_addr = (win == 1) ? a1 : a0;
        s_wd   = (win == 1) ? d1 : d0;

        chk("gnt0",    gnt0,    win == 0);
        chk("gnt1",    gnt1,    win == 1);
        chk("mem_we",  mem_we,  (win >= 0) && s_we);
        chk("mem_addr", mem_address,  (win >= 0) ? s_addr : m_hold_addr);
        chk("mem_wdata", mem_data_out, (win >= 0) ? s_wd : m_hold_wdata);
        chk("rvalid0", rvalid0, m_pend == 0);
        chk("rvalid1", rvalid1, m_pend == 1);
        if (m_pend >= 0) chk("rdata", rdata, m_pend_data);

        last_g0 = gnt0; last_g1 = gnt1; last_rv0 = rvalid0; last_rv1 = rvalid1;
        last_we = mem_we; last_rdata = rdata;

        m_pend = -1;
        if (win >= 0) begin
            if (s_we) begin
                ref_mem[s_addr] = s_wd;
            end else begin
                m_pend      = win;
                m_pend_data = ref_mem.exists(s_addr) ? ref_mem[s_addr] : init_word(s_addr);
            end
            m_hold_addr  = s_addr;
            m_hold_wdata = s_wd;
            m_streak     = (win == m_own) ? m_streak + 1 : 1;
            m_own        = win;
            m_last       = win;
        end else begin
            m_own    = -1;
            m_streak = 0;
        end
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        model_reset();

        // Outputs stay quiet while reset is high, even with both ports requesting.
        repeat (2) @(negedge clk);
        req0 = 1; req1 = 1; addr0 = 32'h40; addr1 = 32'h80; wdata0 = 32'h1234; wdata1 = 32'h5678;
        #1 chk_all_zero("reset_hold");
        @(negedge clk);
        reset = 0; req0 = 0; req1 = 0;

        // Lone read from port 0: same-cycle grant, data one cycle later.
        step(1, 0, 32'h100, '0, 0, 0, '0, '0);
        chk("r037_gnt0", last_g0, 1);
        idle();
        chk("r037_rvalid0", last_rv0, 1);
        chk("r037_rvalid1", last_rv1, 0);
        chk("r037_rdata", last_rdata, init_word(32'h100));

        // Tie from IDLE after a port-0 grant goes to port 1.
        step(1, 0, 32'h200, '0, 1, 0, 32'h204, '0);
        chk("r040_tie_gnt1", last_g1, 1);
        idle();

        // Sustained contention: bursts of four alternate with no idle cycle.
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 32'h300 + i * 4, '0, 1, 1, 32'h400 + i * 4, 32'hA000 + i);
            chk("r038_pattern_gnt1", last_g1, ((i / 4) % 2) == 1);
            chk("r038_pattern_gnt0", last_g0, ((i / 4) % 2) == 0);
        end
        idle();

        // Write from port 1 then read back through port 0.
        step(0, 0, '0, '0, 1, 1, 32'h804, 32'hDEADBEEF);
        chk("r039_we_write", last_we, 1);
        step(1, 0, 32'h804, '0, 0, 0, '0, '0);
        chk("r039_we_read", last_we, 0);
        idle();
        chk("r039_rvalid0", last_rv0, 1);
        chk("r039_rdata", last_rdata, 32'hDEADBEEF);

        // A lone requester is never throttled; its saturated count then yields to a tie.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h900 + i * 4, '0, 0, 0, '0, '0);
            chk("r042_gnt0", last_g0, 1);
        end
        step(1, 0, 32'h940, '0, 1, 0, 32'h944, '0);
        chk("r042_tie_after_sat", last_g1, 1);
        idle();

        // Reset arriving in the cycle of an accepted port-1 read kills the return.
        @(negedge clk);
        req0 = 0; req1 = 1; we1 = 0; addr1 = 32'hC00;
        #1 chk("r041_pre_gnt1", gnt1, 1);
        #1 reset = 1;
        #1 chk_all_zero("r041_in_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk_all_zero("r041_held");
        end
        @(negedge clk);
        reset = 0; req1 = 0;
        model_reset();
        idle();
        chk("r041_no_rvalid1", last_rv1, 0);
        idle();

        // Random traffic over a small address window to exercise read-after-write.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 32'h100 + 4 * $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 32'h100 + 4 * $urandom_range(0, 7), $urandom);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants to one port while the other port is requesting.
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL have parameter DW, default 32, meaning the data width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 bit each: port N requests one memory beat this cycle.
REQ-007 SHALL have ports we0/we1, input, 1 bit each: the beat is a write (1) or a read (0).
REQ-008 SHALL have ports addr0/addr1, input, AW bits each: beat address.
REQ-009 SHALL have ports wdata0/wdata1, input, DW bits each: write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 bit each: beat accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 bit each: read data valid for that port.
REQ-012 SHALL have port rdata, output, DW bits: read data returned to the port flagged by rvalid.
REQ-013 SHALL have port mem_address, output, AW bits: memory address.
REQ-014 SHALL have port mem_data_out, output, DW bits: memory write data.
REQ-015 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-016 SHALL have port mem_data_in, input, DW bits: memory read data, valid one cycle after the address is presented.

Function
REQ-017 SHALL hold state IDLE, OWN0 or OWN1, plus a burst counter (0..MAX_BURST) and a round-robin pointer last_port.
REQ-018 Winner selection each cycle SHALL be combinational: only one port requesting -> that port; neither -> none.
REQ-019 Both requesting, in OWNn with count < MAX_BURST -> port n keeps the grant.
REQ-020 Both requesting, in OWNn with count == MAX_BURST -> the other port wins.
REQ-021 Both requesting, in IDLE -> the port != last_port wins.
REQ-022 gnt of the winner SHALL be asserted in the same cycle as its req (zero-latency accept); at most one gnt SHALL be high per cycle.
REQ-023 mem_address, mem_data_out and mem_we SHALL mirror the winner's addr/wdata/we combinationally.
REQ-024 With no winner, mem_we SHALL be 0 and mem_address/mem_data_out SHALL hold their last driven value.
REQ-025 An accepted read SHALL assert rvalidN exactly one cycle later, with rdata = mem_data_in; an accepted write SHALL produce no rvalid.
REQ-026 Back-to-back beats SHALL be accepted every cycle; throughput SHALL be 1 beat per cycle with no bubbles on owner switch.
REQ-027 Transitions: a grant to port n moves to OWNn; a grant to the same owner increments count, saturating at MAX_BURST; a switch loads count = 1; no grant -> IDLE with count = 0.
REQ-028 last_port SHALL update to the granted port on every grant.
REQ-029 A requester dropping req mid-burst SHALL lose ownership in that cycle, with no penalty.
REQ-030 A single requester SHALL never be throttled by MAX_BURST.

Reset
REQ-031 While reset is high, state SHALL be IDLE, count 0 and last_port 1 (port 0 wins the first tie).
REQ-032 While reset is high, gnt0/gnt1, rvalid0/rvalid1 and mem_we SHALL be 0, and mem_address, mem_data_out and rdata SHALL be 0.
REQ-033 A read accepted in the cycle reset asserts SHALL NOT produce an rvalid after reset is released.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1), the port-id constants and the default AW/DW/MAX_BURST.
REQ-035 The winner logic SHALL live in sub-module mem_arb_pick, which is purely combinational: (req0, req1, state, count, last_port) -> winner, valid.
REQ-036 The arbiter core SHALL hold all flops.

Verification
REQ-037 Reset released, req0 only, read 0x100 -> gnt0 the same cycle; next cycle rvalid0=1, rdata=M[0x100]; rvalid1 stays 0.
REQ-038 Both req held continuously with MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0…; one gnt per cycle; no idle cycle.
REQ-039 req1 alone writes 0xDEADBEEF to 0x804, then req0 reads 0x804 -> mem_we=1 in the write cycle only; rvalid0 with rdata=0xDEADBEEF.
REQ-040 Both req in IDLE after a port-0 grant -> port 1 wins the tie.
REQ-041 Reset asserted in the same cycle as an accepted read from port 1 -> rvalid1 never asserts; all outputs are 0 until reset falls.
REQ-042 Only req0 held for 10 cycles -> 10 consecutive gnt0; count saturates at 4 without stalling.
